pll_lock_supervisor: RTL
========================

# pll_lock_supervisor

Consumer-side companion to the PLL wrapper. Runs on the PLL reference clock and sequences the PLL's reset input. Qualifies the asynchronous `locked` flag and releases a system reset only after lock has been stable for a programmed interval. Also checks the divided output clock's edge rate and re-resets the PLL on lock loss or lock timeout.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: refclk cycles `pll_rst` is held high per reset attempt.
- `LOCK_TIMEOUT`, 65536: refclk cycles allowed in WAIT_LOCK before retrying.
- `SETTLE_CYCLES`, 1024: consecutive cycles with synchronized lock required before release.
- `WINDOW`, 1250: refclk cycles per frequency measurement window.
- `EXP_EDGES`, 8: expected `mon_clk` rising edges per window.
- `TOL`, 1: allowed absolute edge-count deviation.

Ports:
- `refclk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `mon_clk` in 1: PLL output clock (e.g. outclk_1), sampled as data.
- `pll_rst` out 1: reset to the PLL.
- `sys_rst` out 1: downstream reset, active high.
- `ready` out 1: high only in RUN.
- `freq_ok` out 1: the last completed window was within tolerance.
- `loss_cnt` out 8: count of lock losses while in RUN; saturates at 255.
- `state` out 2: 0 RESET_PLL, 1 WAIT_LOCK, 2 SETTLE, 3 RUN.

## Operation
- Synchronizers:
  - `locked` passes through a 2-flop synchronizer to give `locked_s`.
  - `mon_clk` passes through a 2-flop synchronizer plus a third flop for edge detection. A rising edge is sync2=1 and sync3=0.
- FSM and one shared counter `cnt`, cleared on every state entry:
  - RESET_PLL: `pll_rst`=1. When `cnt`=PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: if `locked_s`=1, go to SETTLE. Otherwise, when `cnt`=LOCK_TIMEOUT-1, go to RESET_PLL.
  - SETTLE: if `locked_s`=0, go to WAIT_LOCK. Otherwise, when `cnt`=SETTLE_CYCLES-1, go to RUN.
  - RUN: if `locked_s`=0, go to RESET_PLL and increment `loss_cnt` (saturating).
- Outputs are registered decodes of the next state, so they change on the same edge as `state`:
  - `sys_rst`=0 only in RUN.
  - `ready`=1 only in RUN.
  - `pll_rst`=1 only in RESET_PLL.
- Frequency check, active in RUN only:
  - Window counter runs 0..WINDOW-1. The edge counter is sized for 2*EXP_EDGES and saturates.
  - On the last window cycle: `freq_ok` <= (|edges − EXP_EDGES| ≤ TOL), where edges includes any edge detected in that same cycle. The edge counter and window counter then restart.
  - `freq_ok` does not trigger a PLL reset; it is status only.
  - On leaving RUN: `freq_ok` is cleared and both counters reset.
- Widths: `cnt` is sized by clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT and SETTLE_CYCLES.

## Timing
- Reset values while `rst`=1:
  - state=RESET_PLL, `pll_rst`=1, `sys_rst`=1, `ready`=0, `freq_ok`=0, `loss_cnt`=0.
  - All counters and synchronizer flops are 0.
- After `rst` falls, `pll_rst` stays high for exactly PLL_RST_CYCLES cycles.
- Latency from `locked` rise to `sys_rst` fall: 2 synchronizer cycles + 1 transition cycle + SETTLE_CYCLES.
- Latency from `locked` fall in RUN to `sys_rst`=1 and `pll_rst`=1: 3 cycles (2 sync + 1 register).
- A `locked` glitch during SETTLE restarts the settle count through WAIT_LOCK. No partial credit is kept.
- `rst` asserted mid-operation: immediate asynchronous return to the reset values. `loss_cnt` is cleared.
- First `freq_ok` update: WINDOW cycles after entering RUN.

## Configuration
- `PLL_SUP_FREQ_CHECK_EN` defined: the frequency checker is built as described above.
- Not defined:
  - No `mon_clk` synchronizer and no window or edge counters are built; `mon_clk` is ignored.
  - `freq_ok` equals `ready` (registered, same timing).

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=64, SETTLE_CYCLES=8, WINDOW=40, EXP_EDGES=5, TOL=1.

- Reset and lock:
  - Stimulus: hold `rst` for 3 cycles, then release; raise `locked` at cycle 10.
  - Required response: `pll_rst` high for 4 cycles after release. `sys_rst` falls and `ready` rises at cycle 10+3+8=21.
- Lock timeout:
  - Stimulus: never raise `locked`.
  - Required response: `pll_rst` re-pulses for 4 cycles every 68 cycles; `sys_rst` stays 1.
- Settle glitch:
  - Stimulus: drop `locked` for 2 cycles midway through SETTLE.
  - Required response: `state` goes back to 1, then the full 8-cycle settle is required again.
- Loss in RUN:
  - Stimulus: drop `locked` 3 times while in RUN, with relock each time.
  - Required response: `loss_cnt`=3, and `sys_rst` is asserted 3 cycles after each fall.
  - Stimulus: force `loss_cnt` to 255 and cause one more loss.
  - Required response: `loss_cnt` stays 255.
- Frequency check (macro defined):
  - Stimulus: `mon_clk` period 8 (5 edges per window). Required response: `freq_ok`=1 after the first window.
  - Stimulus: period 5 (8 edges). Required response: `freq_ok`=0.
  - Stimulus: period 10 (4 edges). Required response: `freq_ok`=1.
- Macro undefined:
  - Stimulus: toggle `mon_clk` arbitrarily.
  - Required response: `freq_ok` tracks `ready` exactly.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences the PLL reset input from the reference clock domain, qualifies
//   the asynchronous PLL lock flag, and releases the system reset only after
//   lock has been continuously present for SETTLE_CYCLES. Lock loss in RUN or
//   a lock timeout re-resets the PLL. Optionally measures the edge rate of a
//   divided PLL output clock over fixed windows.
//
//   Build option:
//     PLL_SUP_FREQ_CHECK_EN  defined   -> mon_clk edge-rate checker built,
//                                         freq_ok reports the last window.
//                            undefined -> mon_clk ignored, freq_ok == ready.
//
//   Ports:
//     refclk   in   reference clock (the only clock)
//     rst      in   asynchronous active-high reset
//     locked   in   PLL lock flag, asynchronous to refclk
//     mon_clk  in   PLL output clock, sampled as data
//     pll_rst  out  reset to the PLL (high in RESET_PLL)
//     sys_rst  out  downstream reset, low only in RUN
//     ready    out  high only in RUN
//     freq_ok  out  last completed measurement window within tolerance
//     loss_cnt out  lock losses seen in RUN, saturating at 255
//     state    out  0 RESET_PLL, 1 WAIT_LOCK, 2 SETTLE, 3 RUN
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned WINDOW         = 1250,
    parameter int unsigned EXP_EDGES      = 8,
    parameter int unsigned TOL            = 1
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       mon_clk,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       freq_ok,
    output logic [7:0] loss_cnt,
    output logic [1:0] state
);

    localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [1:0] S_RESET_PLL = 2'd0;
    localparam logic [1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [1:0] S_SETTLE    = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    logic             r_lock_s1;
    logic             r_lock_s2;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_next;

    // Lock flag synchronizer
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_lock_s1 <= locked;
            r_lock_s2 <= r_lock_s1;
        end
    end

    // A live lock flag takes priority over the timeout in WAIT_LOCK
    always_comb begin
        w_next = state;
        case (state)
            S_RESET_PLL: begin
                if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) w_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (r_lock_s2)                                w_next = S_SETTLE;
                else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1))   w_next = S_RESET_PLL;
            end
            S_SETTLE: begin
                if (!r_lock_s2)                               w_next = S_WAIT_LOCK;
                else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1))  w_next = S_RUN;
            end
            S_RUN: begin
                if (!r_lock_s2)                               w_next = S_RESET_PLL;
            end
            default: w_next = S_RESET_PLL;
        endcase
    end

    // Outputs decode the next state so they switch on the same edge as state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state    <= S_RESET_PLL;
            r_cnt    <= '0;
            pll_rst  <= 1'b1;
            sys_rst  <= 1'b1;
            ready    <= 1'b0;
            loss_cnt <= '0;
        end else begin
            state   <= w_next;
            pll_rst <= (w_next == S_RESET_PLL);
            sys_rst <= (w_next != S_RUN);
            ready   <= (w_next == S_RUN);
            if (w_next != state)
                r_cnt <= '0;
            else if (state != S_RUN)
                r_cnt <= r_cnt + CNT_W'(1);
            if ((state == S_RUN) && !r_lock_s2 && (loss_cnt != 8'hFF))
                loss_cnt <= loss_cnt + 8'd1;
        end
    end

`ifdef PLL_SUP_FREQ_CHECK_EN
    localparam int unsigned EDGE_MAX = 2 * EXP_EDGES;
    localparam int unsigned EDGE_W   = (EDGE_MAX > 0) ? $clog2(EDGE_MAX + 1) : 1;
    localparam int unsigned WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic              r_mon_s1;
    logic              r_mon_s2;
    logic              r_mon_s3;
    logic [WIN_W-1:0]  r_win;
    logic [EDGE_W-1:0] r_edges;
    logic              w_rise;
    logic [31:0]       w_edges_raw;
    logic [31:0]       w_edges_tot;
    logic              w_win_ok;

    assign w_rise      = r_mon_s2 & ~r_mon_s3;
    // Count includes an edge detected on the closing cycle of the window
    assign w_edges_raw = 32'(r_edges) + 32'(w_rise);
    assign w_edges_tot = (w_edges_raw > EDGE_MAX) ? EDGE_MAX : w_edges_raw;
    assign w_win_ok    = ((w_edges_tot + TOL) >= EXP_EDGES) && (w_edges_tot <= (EXP_EDGES + TOL));

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_mon_s1 <= 1'b0;
            r_mon_s2 <= 1'b0;
            r_mon_s3 <= 1'b0;
            r_win    <= '0;
            r_edges  <= '0;
            freq_ok  <= 1'b0;
        end else begin
            r_mon_s1 <= mon_clk;
            r_mon_s2 <= r_mon_s1;
            r_mon_s3 <= r_mon_s2;
            // Counters only run while staying in RUN; the entry edge starts window at 0
            if ((state != S_RUN) || (w_next != S_RUN)) begin
                r_win   <= '0;
                r_edges <= '0;
                freq_ok <= 1'b0;
            end else if (r_win == WIN_W'(WINDOW - 1)) begin
                r_win   <= '0;
                r_edges <= '0;
                freq_ok <= w_win_ok;
            end else begin
                r_win   <= r_win + WIN_W'(1);
                r_edges <= EDGE_W'(w_edges_tot);
            end
        end
    end
`else
    logic w_unused_mon;
    assign w_unused_mon = mon_clk;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) freq_ok <= 1'b0;
        else     freq_ok <= (w_next == S_RUN);
    end
`endif

endmodule
